// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe controller: cell owners, game states,
// line-scan directions and the row-major cell index helper.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    WIN   = 2'd2,
    DRAW  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_t;

  function automatic int cell_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Command/status bundle between the key front-end, the game controller and the
// board renderer. Score ports exist only when TTT_SCORE_EN is defined.
interface ttt_game_ctrl_if #(
  parameter int N  = 3,
  parameter int CW = 10
);
  logic [3:0]       iMove;
  logic             iPlace;
  logic             iNewGame;
  logic [CW-1:0]    oCursor_X;
  logic [CW-1:0]    oCursor_Y;
  logic [2*N*N-1:0] oBoard;
  logic [1:0]       oPlayer;
  logic [1:0]       oState;
  logic [1:0]       oWinner;
  logic             oIllegal;
`ifdef TTT_SCORE_EN
  logic [7:0]       oScore1;
  logic [7:0]       oScore2;

  modport master (output iMove, iPlace, iNewGame,
                  input  oCursor_X, oCursor_Y, oBoard, oPlayer, oState,
                         oWinner, oIllegal, oScore1, oScore2);
  modport slave  (input  iMove, iPlace, iNewGame,
                  output oCursor_X, oCursor_Y, oBoard, oPlayer, oState,
                         oWinner, oIllegal, oScore1, oScore2);
`else
  modport master (output iMove, iPlace, iNewGame,
                  input  oCursor_X, oCursor_Y, oBoard, oPlayer, oState,
                         oWinner, oIllegal);
  modport slave  (input  iMove, iPlace, iNewGame,
                  output oCursor_X, oCursor_Y, oBoard, oPlayer, oState,
                         oWinner, oIllegal);
`endif
endinterface

// File: rtl/ttt_line_count.sv
// Combinational run-length of one player's cells through a given cell along one
// direction, scanning at most K-1 cells each way (result never exceeds 2K-1).
module ttt_line_count
  import ttt_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [2*N*N-1:0]       board,
  input  logic [$clog2(N)-1:0]   row,
  input  logic [$clog2(N)-1:0]   col,
  input  dir_t                   dir,
  input  logic [1:0]             player,
  output logic [$clog2(2*K)-1:0] count
);

  localparam int CNTW = $clog2(2*K);

  int   dr;
  int   dc;
  int   cnt;
  logic run;

  // Off-board coordinates read as EMPTY so a scan stops at the edge.
  function automatic logic [1:0] owner_at(input logic [2*N*N-1:0] b,
                                          input int r, input int c);
    if (r < 0 || r >= N || c < 0 || c >= N) return EMPTY;
    return b[2*cell_idx(r, c, N) +: 2];
  endfunction

  always_comb begin
    dr = 0;
    dc = 1;
    case (dir)
      DIR_H:   begin dr = 0; dc = 1;  end
      DIR_V:   begin dr = 1; dc = 0;  end
      DIR_D:   begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase

    cnt = (owner_at(board, int'(row), int'(col)) == player) ? 1 : 0;

    run = 1'b1;
    for (int s = 1; s < K; s++) begin
      if (run && owner_at(board, int'(row) + s*dr, int'(col) + s*dc) == player)
        cnt = cnt + 1;
      else
        run = 1'b0;
    end

    run = 1'b1;
    for (int s = 1; s < K; s++) begin
      if (run && owner_at(board, int'(row) - s*dr, int'(col) - s*dc) == player)
        cnt = cnt + 1;
      else
        run = 1'b0;
    end

    count = CNTW'(cnt);
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// N x N, K-in-a-row tic-tac-toe controller: cursor, placement, 4-cycle win scan.
// Define TTT_SCORE_EN to add saturating per-player win counters.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int N      = 3,
  parameter int K      = 3,
  parameter int ORIGIN = 70,
  parameter int PITCH  = 160,
  parameter int CW     = 10
) (
  input  logic          iCLK,
  input  logic          iRST,
  ttt_game_ctrl_if.slave bus
);

  localparam int RW   = $clog2(N);
  localparam int MCW  = $clog2(N*N + 1);
  localparam int CNTW = $clog2(2*K);
  localparam int BW   = 2*N*N;

  logic [RW-1:0]   col_q, col_d, row_q, row_d;
  logic [RW-1:0]   lcol_q, lcol_d, lrow_q, lrow_d;
  logic [CW-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [BW-1:0]   board_q, board_d;
  logic [1:0]      player_q, player_d, winner_q, winner_d;
  logic            illegal_q, illegal_d, hit_q, hit_d, found;
  logic [MCW-1:0]  moves_q, moves_d;
  state_t          state_q, state_d;
  dir_t            dir_q, dir_d;
  logic [CNTW-1:0] line_cnt;
  int              place_idx;
`ifdef TTT_SCORE_EN
  logic [7:0]      score1_q, score1_d, score2_q, score2_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction
`endif

  ttt_line_count #(.N(N), .K(K)) u_line (
    .board  (board_q),
    .row    (lrow_q),
    .col    (lcol_q),
    .dir    (dir_q),
    .player (player_q),
    .count  (line_cnt)
  );

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    lcol_d    = lcol_q;
    lrow_d    = lrow_q;
    board_d   = board_q;
    player_d  = player_q;
    winner_d  = winner_q;
    illegal_d = 1'b0;
    hit_d     = hit_q;
    moves_d   = moves_q;
    state_d   = state_q;
    dir_d     = dir_q;
`ifdef TTT_SCORE_EN
    score1_d  = score1_q;
    score2_d  = score2_q;
`endif
    place_idx = cell_idx(int'(row_q), int'(col_q), N);
    found     = hit_q || (int'(line_cnt) >= K);

    if (bus.iNewGame) begin
      board_d  = '0;
      player_d = P1;
      winner_d = EMPTY;
      moves_d  = '0;
      hit_d    = 1'b0;
      dir_d    = DIR_H;
      state_d  = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          // Opposing pulses on one axis cancel; the two axes are independent.
          if (bus.iMove[0] && !bus.iMove[1])
            col_d = (col_q == RW'(N-1)) ? '0 : col_q + 1'b1;
          else if (bus.iMove[1] && !bus.iMove[0])
            col_d = (col_q == '0) ? RW'(N-1) : col_q - 1'b1;
          if (bus.iMove[2] && !bus.iMove[3])
            row_d = (row_q == RW'(N-1)) ? '0 : row_q + 1'b1;
          else if (bus.iMove[3] && !bus.iMove[2])
            row_d = (row_q == '0) ? RW'(N-1) : row_q - 1'b1;

          // Placement uses the cursor as it was before this cycle's move.
          if (bus.iPlace) begin
            if (board_q[2*place_idx +: 2] == EMPTY) begin
              board_d[2*place_idx +: 2] = player_q;
              moves_d = moves_q + 1'b1;
              lrow_d  = row_q;
              lcol_d  = col_q;
              hit_d   = 1'b0;
              dir_d   = DIR_H;
              state_d = CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        CHECK: begin
          hit_d = found;
          if (dir_q == DIR_A) begin
            if (found) begin
              state_d  = WIN;
              winner_d = player_q;
`ifdef TTT_SCORE_EN
              if (player_q == P1) score1_d = sat_inc(score1_q);
              else                score2_d = sat_inc(score2_q);
`endif
            end else if (moves_q == MCW'(N*N)) begin
              state_d = DRAW;
            end else begin
              state_d  = PLAY;
              player_d = (player_q == P1) ? P2 : P1;
            end
          end else begin
            dir_d = dir_t'(dir_q + 2'd1);
          end
        end
        default: ;
      endcase
    end

    cur_x_d = CW'(ORIGIN + int'(col_d) * PITCH);
    cur_y_d = CW'(ORIGIN + int'(row_d) * PITCH);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_q     <= '0;
      row_q     <= '0;
      lcol_q    <= '0;
      lrow_q    <= '0;
      cur_x_q   <= CW'(ORIGIN);
      cur_y_q   <= CW'(ORIGIN);
      board_q   <= '0;
      player_q  <= P1;
      winner_q  <= EMPTY;
      illegal_q <= 1'b0;
      hit_q     <= 1'b0;
      moves_q   <= '0;
      state_q   <= PLAY;
      dir_q     <= DIR_H;
`ifdef TTT_SCORE_EN
      score1_q  <= '0;
      score2_q  <= '0;
`endif
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      lcol_q    <= lcol_d;
      lrow_q    <= lrow_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      board_q   <= board_d;
      player_q  <= player_d;
      winner_q  <= winner_d;
      illegal_q <= illegal_d;
      hit_q     <= hit_d;
      moves_q   <= moves_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
`ifdef TTT_SCORE_EN
      score1_q  <= score1_d;
      score2_q  <= score2_d;
`endif
    end
  end

  assign bus.oCursor_X = cur_x_q;
  assign bus.oCursor_Y = cur_y_q;
  assign bus.oBoard    = board_q;
  assign bus.oPlayer   = player_q;
  assign bus.oState    = state_q;
  assign bus.oWinner   = winner_q;
  assign bus.oIllegal  = illegal_q;
`ifdef TTT_SCORE_EN
  assign bus.oScore1   = score1_q;
  assign bus.oScore2   = score2_q;
`endif

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: a 3x3/K=3 instance and a 5x5/K=4 instance
// on one clock and reset, with hand-computed expected outputs.
module tb_ttt_game_ctrl;
  import ttt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ttt_game_ctrl_if #(.N(3), .CW(10)) b3();
  ttt_game_ctrl_if #(.N(5), .CW(10)) b5();

  ttt_game_ctrl #(.N(3), .K(3), .ORIGIN(70), .PITCH(160), .CW(10)) u3 (
    .iCLK(clk), .iRST(rst), .bus(b3));
  ttt_game_ctrl #(.N(5), .K(4), .ORIGIN(70), .PITCH(160), .CW(10)) u5 (
    .iCLK(clk), .iRST(rst), .bus(b5));

  int errors = 0;
  int checks = 0;
  int cur_r[2] = '{0, 0};
  int cur_c[2] = '{0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle command pulse on instance w (0: 3x3, 1: 5x5); returns #1 after the edge.
  task automatic drv(input int w, input logic [3:0] mv, input logic pl, input logic ng);
    if (w == 0) begin b3.iMove = mv; b3.iPlace = pl; b3.iNewGame = ng; end
    else        begin b5.iMove = mv; b5.iPlace = pl; b5.iNewGame = ng; end
    @(posedge clk);
    #1;
    b3.iMove = 4'b0; b3.iPlace = 1'b0; b3.iNewGame = 1'b0;
    b5.iMove = 4'b0; b5.iPlace = 1'b0; b5.iNewGame = 1'b0;
  endtask

  function automatic logic [1:0] st(input int w);
    return (w == 0) ? b3.oState : b5.oState;
  endfunction

  task automatic goto(input int w, input int r, input int c);
    int n;
    n = (w == 0) ? 3 : 5;
    while (cur_c[w] != c) begin drv(w, 4'b0001, 1'b0, 1'b0); cur_c[w] = (cur_c[w] + 1) % n; end
    while (cur_r[w] != r) begin drv(w, 4'b0100, 1'b0, 1'b0); cur_r[w] = (cur_r[w] + 1) % n; end
  endtask

  // Place at (r,c), confirm the scan started, then wait out the 4 scan cycles.
  task automatic place(input int w, input int r, input int c);
    goto(w, r, c);
    drv(w, 4'b0, 1'b1, 1'b0);
    check("in_check", st(w), CHECK);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic p1_row0_win;
    place(0, 0, 0); place(0, 1, 0); place(0, 0, 1); place(0, 1, 1); place(0, 0, 2);
  endtask

  initial begin
    b3.iMove = 4'b0; b3.iPlace = 1'b0; b3.iNewGame = 1'b0;
    b5.iMove = 4'b0; b5.iPlace = 1'b0; b5.iNewGame = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_x",       b3.oCursor_X, 10'd70);
    check("rst_y",       b3.oCursor_Y, 10'd70);
    check("rst_board",   b3.oBoard,    18'h0);
    check("rst_player",  b3.oPlayer,   2'd1);
    check("rst_state",   b3.oState,    2'd0);
    check("rst_winner",  b3.oWinner,   2'd0);
    check("rst_illegal", b3.oIllegal,  1'b0);
    rst = 1'b0;

    // Cursor movement and wrap
    drv(0, 4'b0001, 1'b0, 1'b0); check("right1_x", b3.oCursor_X, 10'd230);
    drv(0, 4'b0001, 1'b0, 1'b0); check("right2_x", b3.oCursor_X, 10'd390);
    drv(0, 4'b0001, 1'b0, 1'b0); check("right3_x", b3.oCursor_X, 10'd70);
    drv(0, 4'b1000, 1'b0, 1'b0); check("up_wrap_y", b3.oCursor_Y, 10'd390);
    drv(0, 4'b0100, 1'b0, 1'b0); check("down_wrap_y", b3.oCursor_Y, 10'd70);
    drv(0, 4'b0010, 1'b0, 1'b0); check("left_wrap_x", b3.oCursor_X, 10'd390);
    drv(0, 4'b0001, 1'b0, 1'b0); check("right_back_x", b3.oCursor_X, 10'd70);
    drv(0, 4'b1111, 1'b0, 1'b0);
    check("cancel_x", b3.oCursor_X, 10'd70);
    check("cancel_y", b3.oCursor_Y, 10'd70);
    drv(0, 4'b0101, 1'b0, 1'b0);
    check("diag_x", b3.oCursor_X, 10'd230);
    check("diag_y", b3.oCursor_Y, 10'd230);
    drv(0, 4'b1010, 1'b0, 1'b0);
    check("diag_back_y", b3.oCursor_Y, 10'd70);

    // First placement and an illegal retry on the same cell
    place(0, 0, 0);
    check("p1_board",  b3.oBoard,  18'h1);
    check("p1_player", b3.oPlayer, 2'd2);
    check("p1_state",  b3.oState,  2'd0);
    drv(0, 4'b0, 1'b1, 1'b0);
    check("illegal_hi",     b3.oIllegal, 1'b1);
    check("illegal_board",  b3.oBoard,   18'h1);
    check("illegal_player", b3.oPlayer,  2'd2);
    check("illegal_state",  b3.oState,   2'd0);
    @(posedge clk); #1;
    check("illegal_lo", b3.oIllegal, 1'b0);

    // Top-row win for P1
    place(0, 1, 0); place(0, 0, 1); place(0, 1, 1); place(0, 0, 2);
    check("win_state",  b3.oState,  2'd2);
    check("win_winner", b3.oWinner, 2'd1);
    check("win_row0",   b3.oBoard[5:0], 6'b010101);
    check("win_board",  b3.oBoard,  18'h295);
    drv(0, 4'b0001, 1'b1, 1'b0);
    check("win_nomove_x", b3.oCursor_X, 10'd390);
    check("win_hold",     b3.oState,    2'd2);
    check("win_noillegal", b3.oIllegal, 1'b0);
    drv(0, 4'b0, 1'b0, 1'b1);
    check("ng_board",  b3.oBoard,   18'h0);
    check("ng_player", b3.oPlayer,  2'd1);
    check("ng_state",  b3.oState,   2'd0);
    check("ng_winner", b3.oWinner,  2'd0);
    check("ng_cursor", b3.oCursor_X, 10'd390);

    // Draw: X O X / X O O / O X X
    place(0, 0, 0); place(0, 0, 1); place(0, 0, 2); place(0, 1, 1); place(0, 1, 0);
    place(0, 1, 2); place(0, 2, 1); place(0, 2, 0); place(0, 2, 2);
    check("draw_state",  b3.oState,  2'd3);
    check("draw_winner", b3.oWinner, 2'd0);
    check("draw_board",  b3.oBoard,  18'h16A59);
    drv(0, 4'b1000, 1'b1, 1'b0);
    check("draw_hold",    b3.oState,    2'd3);
    check("draw_nomove",  b3.oCursor_Y, 10'd390);
    check("draw_board2",  b3.oBoard,    18'h16A59);
    drv(0, 4'b0, 1'b0, 1'b1);
    check("ng2_board",  b3.oBoard,  18'h0);
    check("ng2_player", b3.oPlayer, 2'd1);
    check("ng2_state",  b3.oState,  2'd0);

    // 5x5, K=4: P2 anti-diagonal, 3 cells not enough
    place(1, 4, 4); place(1, 0, 4); place(1, 3, 4); place(1, 1, 3); place(1, 4, 3);
    place(1, 2, 2);
    check("k4_three_state",  b5.oState,  2'd0);
    check("k4_three_winner", b5.oWinner, 2'd0);
    check("k4_three_player", b5.oPlayer, 2'd1);
    place(1, 4, 1); place(1, 3, 1);
    check("k4_win_state",  b5.oState,  2'd2);
    check("k4_win_winner", b5.oWinner, 2'd2);

    // Asynchronous reset in the middle of a scan
    goto(0, 1, 1);
    drv(0, 4'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_state",  b3.oState,    2'd0);
    check("arst_board",  b3.oBoard,    18'h0);
    check("arst_player", b3.oPlayer,   2'd1);
    check("arst_winner", b3.oWinner,   2'd0);
    check("arst_x",      b3.oCursor_X, 10'd70);
    check("arst_y",      b3.oCursor_Y, 10'd70);
    check("arst_k4",     b5.oState,    2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cur_r = '{0, 0};
    cur_c = '{0, 0};

`ifdef TTT_SCORE_EN
    check("score_rst1", b3.oScore1, 8'd0);
    p1_row0_win();
    drv(0, 4'b0, 1'b0, 1'b1);
    p1_row0_win();
    check("score1", b3.oScore1, 8'd2);
    check("score2", b3.oScore2, 8'd0);
`else
    p1_row0_win();
    check("rewin_winner", b3.oWinner, 2'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Parametrised tic-tac-toe game controller: N×N board, K-in-a-row win rule, cursor, turn alternation, legality check, win/draw detection.
- Replaces the ad-hoc key-edge-clocked logic in the top level. Runs on the system clock with one-cycle command pulses from a debouncer/edge detector.
- Feeds the board renderer with cursor pixel position and packed board state.

Parameters:
N, 3, board dimension (3..8)
K, 3, contiguous cells needed to win (3..N)
ORIGIN, 70, pixel coordinate of cell 0 centre (X and Y)
PITCH, 160, pixel distance between adjacent cell centres
CW, 10, width of pixel coordinate outputs

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous reset, active-high
iMove  in  4  one-cycle pulses: [0] right, [1] left, [2] down, [3] up
iPlace  in  1  one-cycle pulse: claim the cell under the cursor
iNewGame  in  1  one-cycle pulse: clear board, start a new game
oCursor_X  out  CW  cursor centre X pixel = ORIGIN + col*PITCH
oCursor_Y  out  CW  cursor centre Y pixel = ORIGIN + row*PITCH
oBoard  out  2*N*N  cell idx = row*N+col at bits [2*idx+1:2*idx]; 0 empty, 1 P1, 2 P2 (3 never driven)
oPlayer  out  2  player to move (1 or 2)
oState  out  2  0 PLAY, 1 CHECK, 2 WIN, 3 DRAW
oWinner  out  2  winning player in WIN, else 0
oIllegal  out  1  one-cycle pulse when iPlace targets an occupied cell

Behaviour:
- Reset (async, iRST=1): cursor col=row=0, so oCursor_X = oCursor_Y = ORIGIN. oBoard=0, oPlayer=1, oState=PLAY, oWinner=0, oIllegal=0, move counter=0. All outputs are registered.
- iNewGame has highest priority in any state. Next cycle: board cleared, oPlayer=1, PLAY, oWinner=0, counter=0. Cursor is not moved.
- Movement (PLAY only): col/row change by 1 with wrap. Right from N-1 goes to 0; left from 0 goes to N-1; same for down/up. An opposing pair in the same cycle (right+left, or down+up) cancels on that axis. Horizontal and vertical moves in the same cycle both apply. Pixel outputs update one cycle after the pulse.
- iPlace in PLAY:
  - Targets the pre-move cursor cell if a move arrives in the same cycle.
  - If the cell is empty: write oPlayer into it, increment the counter, latch the cell coordinates, go to CHECK.
  - If the cell is occupied: oIllegal=1 for one cycle; board, player and state unchanged.
- CHECK lasts exactly 4 cycles, one per direction d=0..3 (horizontal, vertical, diagonal, anti-diagonal).
  - Each cycle counts contiguous cells owned by the placing player through the latched cell. Scan up to K-1 cells each way, stopping at the board edge or a non-matching cell.
  - A sticky hit flag is set if any direction's count is ≥ K.
  - After d=3:
    - hit → WIN, oWinner = placing player.
    - else counter == N*N → DRAW.
    - else → PLAY with oPlayer toggled.
  - Latency: iPlace to the final state is 5 cycles.
- In CHECK, WIN and DRAW, iMove and iPlace are ignored; only iNewGame acts. iNewGame during CHECK aborts the check.
- The counter is ceil(log2(N*N+1)) bits wide and never exceeds N*N.

Optional Feature:
- Macro TTT_SCORE_EN.
- When defined, adds ports oScore1 and oScore2 (out, 8 bits). A counter increments on entry to WIN for the winning player and saturates at 255. Scores are cleared only by iRST; iNewGame preserves them.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package ttt_pkg holds:
  - owner codes (EMPTY=0, P1=1, P2=2)
  - state encoding (PLAY, CHECK, WIN, DRAW)
  - direction encoding (DIR_H, DIR_V, DIR_D, DIR_A)
  - a cell-index function
- Sub-module ttt_line_count: combinational. Inputs are board, cell row/col, direction and player; output is the contiguous count, capped at 2K-1. It is instantiated once and driven by the CHECK direction counter.

Test Plan:
- Reset, then 3 right pulses with N=3 → cursor col 0→1→2→0; oCursor_X 70→230→390→70. One up pulse from row 0 → oCursor_Y=390.
- P1 places (0,0), P2 (1,0), P1 (0,1), P2 (1,1), P1 (0,2) → 5 cycles after the last iPlace, oState=WIN, oWinner=1, oBoard[5:0]=6'b010101.
- iPlace on an occupied cell → oIllegal high for exactly 1 cycle; oBoard and oPlayer unchanged; oState stays PLAY.
- Fill a 3×3 board with no line (X O X / X O O / O X X) → after the 9th placement, DRAW with oWinner=0. Further iPlace/iMove is ignored; iNewGame → board 0, oPlayer=1, PLAY.
- N=5, K=4: anti-diagonal (0,4),(1,3),(2,2),(3,1) for P2 → WIN, oWinner=2. The same with only 3 cells gives no win.
- iRST asserted mid-CHECK → all outputs immediately at reset values. With TTT_SCORE_EN, after two P1 wins separated by iNewGame → oScore1=2, oScore2=0.
